// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM states,
// result one-hot codes and the helper that builds a result code.
package seq_mag_cmp_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Result code layout is {gt, lt, eq}; exactly one bit is set after a compare.
  typedef logic [2:0] res_t;

  localparam res_t RES_EQ = 3'b001;
  localparam res_t RES_LT = 3'b010;
  localparam res_t RES_GT = 3'b100;

  function automatic res_t res_code(input logic mismatch, input logic gt);
    if (!mismatch) return RES_EQ;
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/seq_mag_cmp_if.sv
// Request/result bundle of the sequential comparator: the master issues
// start with operands, the slave returns busy, the done pulse and the results.
interface seq_mag_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic             agtb;
  logic             altb;

  modport master (output start, a, b, input busy, done, aeqb, agtb, altb);
  modport slave  (input start, a, b, output busy, done, aeqb, agtb, altb);
endinterface

// File: rtl/seq_mag_cmp_slice.sv
// Combinational CHUNK-bit magnitude compare. With i_signed_msb set the slice
// is read as two's complement, done by flipping its sign bit before an unsigned compare.
module cmp_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_signed_msb,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  logic [CHUNK-1:0] w_flip;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  assign w_flip = CHUNK'(i_signed_msb) << (CHUNK - 1);
  assign w_a    = i_a ^ w_flip;
  assign w_b    = i_b ^ w_flip;

  assign o_eq = (w_a == w_b);
  assign o_gt = (w_a >  w_b);
  assign o_lt = (w_a <  w_b);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator: one CHUNK-bit slice per clock,
// MSB slice first, with start/busy/done handshake. WIDTH must be a multiple of CHUNK.
module seq_mag_cmp
  import seq_mag_cmp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHUNK      = DEF_CHUNK,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_mag_cmp_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic             r_gt;
  logic             r_done;
  res_t             r_res;

  logic [NCHUNK-1:0][CHUNK-1:0] w_a_sl;
  logic [NCHUNK-1:0][CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic             w_smsb;
  logic             w_seq;
  logic             w_sgt;
  logic             w_slt;
  logic             w_last;
  logic             w_fin;
  logic             w_busy;
  logic             w_load;
  res_t             w_res;

  // Slice mux on the captured operands
  assign w_a_sl = r_a;
  assign w_b_sl = r_b;
  assign w_sa   = w_a_sl[r_idx];
  assign w_sb   = w_b_sl[r_idx];
  assign w_smsb = (SIGNED != 0) && (r_idx == TOP_IDX);
  assign w_last = (r_idx == '0);

  cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a          (w_sa),
    .i_b          (w_sb),
    .i_signed_msb (w_smsb),
    .o_eq         (w_seq),
    .o_gt         (w_sgt),
    .o_lt         (w_slt)
  );

  assign w_fin = (r_state == ST_RUN) && (w_last || ((EARLY_EXIT != 0) && !w_seq));

  // A latched earlier mismatch outranks the current slice (full-run mode).
  assign w_res = r_found ? res_code(1'b1, r_gt) : {w_sgt, w_slt, w_seq};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)           w_next = ST_RUN;
      ST_RUN:  if (w_fin && !bus.start) w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  // start is honoured when idle, or on the completing edge so back-to-back
  // compares run without a bubble; it is ignored on every other busy edge.
  always_comb begin
    w_busy = (r_state == ST_RUN);
    w_load = bus.start && (!w_busy || w_fin);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_gt    <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) r_res <= w_res;
      if (w_load) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_idx   <= TOP_IDX;
        r_found <= 1'b0;
        r_gt    <= 1'b0;
      end else if (w_busy) begin
        r_idx <= r_idx - 1'b1;
        if (!w_seq && !r_found) begin
          r_found <= 1'b1;
          r_gt    <= w_sgt;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign {bus.agtb, bus.altb, bus.aeqb} = r_res;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Bench for seq_mag_cmp: four instances (SIGNED x EARLY_EXIT) share one stimulus
// stream; a table of hand-computed vectors, corner sequences and random operands.
module tb_seq_mag_cmp;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [3:0] done_v, busy_v, eq_v, gt_v, lt_v;
  logic [3:0][2:0] last_er = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // g[0] = SIGNED, g<2 -> EARLY_EXIT
  for (genvar g = 0; g < 4; g++) begin : G
    seq_mag_cmp_if #(.WIDTH(8)) bus ();
    seq_mag_cmp #(
      .WIDTH(8), .CHUNK(2), .SIGNED(g % 2), .EARLY_EXIT((g < 2) ? 1 : 0)
    ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign done_v[g] = bus.done;
    assign busy_v[g] = bus.busy;
    assign eq_v[g]   = bus.aeqb;
    assign gt_v[g]   = bus.agtb;
    assign lt_v[g]   = bus.altb;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res_u;
    logic [2:0] res_s;
    int         lat_e;
  } vec_t;

  localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int g);
    return {gt_v[g], lt_v[g], eq_v[g]};
  endfunction

  function automatic logic [11:0] all_res();
    return {res_of(3), res_of(2), res_of(1), res_of(0)};
  endfunction

  // Reference: whole-operand compare as integers
  function automatic logic [2:0] m_res(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    int ix, iy;
    ix = x; iy = y;
    if (sgn && x[7]) ix -= 256;
    if (sgn && y[7]) iy -= 256;
    if (ix > iy) return GT;
    if (ix < iy) return LT;
    return EQ;
  endfunction

  // Reference latency: early exit stops at the 2-bit slice holding the highest differing bit
  function automatic int m_lat(input logic [7:0] x, input logic [7:0] y, input bit ee);
    if (!ee || x == y) return 4;
    for (int p = 7; p >= 0; p--)
      if (x[p] != y[p]) return 4 - p / 2;
    return 4;
  endfunction

  task automatic run_cmp(input logic [7:0] va, input logic [7:0] vb, input bit junk,
                         input logic [3:0][2:0] er, input logic [3:0][3:0] el);
    int         lat[4];
    logic [2:0] got[4];
    for (int g = 0; g < 4; g++) begin lat[g] = 0; got[g] = '0; end
    @(negedge clk); a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = junk;
    if (junk) begin a = ~va; b = ~vb; end
    check("busy_after_start", {28'd0, busy_v}, 32'hF);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (done_v[g] && lat[g] == 0) begin
          lat[g] = n;
          got[g] = res_of(g);
        end else if (lat[g] == 0) begin
          check($sformatf("hold_while_busy[%0d]", g), {29'd0, res_of(g)}, {29'd0, last_er[g]});
        end
      end
      if (n >= 3) start = 1'b0;
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("latency[%0d] a=%0h b=%0h", g, va, vb), lat[g], {28'd0, el[g]});
      check($sformatf("result[%0d] a=%0h b=%0h", g, va, vb), {29'd0, got[g]}, {29'd0, er[g]});
      last_er[g] = er[g];
    end
    check("idle_after", {28'd0, busy_v}, 32'h0);
  endtask

  task automatic run_model(input logic [7:0] va, input logic [7:0] vb, input bit junk);
    logic [3:0][2:0] er;
    logic [3:0][3:0] el;
    for (int g = 0; g < 4; g++) begin
      er[g] = m_res(va, vb, g[0]);
      el[g] = 4'(m_lat(va, vb, g < 2));
    end
    run_cmp(va, vb, junk, er, el);
  endtask

  initial begin
    vec_t tbl[8];
    logic [3:0][2:0] er;
    logic [3:0][3:0] el;
    logic [7:0] bb_a[5], bb_b[5];
    logic [3:0] seen;

    tbl[0] = '{8'hA5, 8'hA5, EQ, EQ, 4};
    tbl[1] = '{8'h80, 8'h7F, GT, LT, 1};
    tbl[2] = '{8'h12, 8'h13, LT, LT, 4};
    tbl[3] = '{8'h40, 8'h00, GT, GT, 1};
    tbl[4] = '{8'h00, 8'hFF, LT, GT, 1};
    tbl[5] = '{8'hFF, 8'hFE, GT, GT, 4};
    tbl[6] = '{8'h3C, 8'h34, GT, GT, 3};
    tbl[7] = '{8'hC0, 8'h80, GT, GT, 1};

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", {17'd0, busy_v, done_v, all_res()}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Hand-computed vectors across all four configurations
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 4; g++) begin
        er[g] = g[0] ? tbl[i].res_s : tbl[i].res_u;
        el[g] = (g < 2) ? 4'(tbl[i].lat_e) : 4'd4;
      end
      run_cmp(tbl[i].a, tbl[i].b, 1'b0, er, el);
    end

    // start with other operands while busy must be ignored
    for (int g = 0; g < 4; g++) begin er[g] = LT; el[g] = 4'd4; end
    run_cmp(8'h12, 8'h13, 1'b1, er, el);

    // start held high: one done every 4 cycles, operands alternate
    bb_a = '{8'h12, 8'h13, 8'h12, 8'h13, 8'h00};
    bb_b = '{8'h13, 8'h12, 8'h13, 8'h12, 8'h00};
    @(negedge clk); a = bb_a[0]; b = bb_b[0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk); a = bb_a[1]; b = bb_b[1];
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); @(negedge clk);
      if (n % 4 == 0) begin
        check($sformatf("b2b_done@%0d", n), {28'd0, done_v}, 32'hF);
        for (int g = 0; g < 4; g++) last_er[g] = m_res(bb_a[n/4-1], bb_b[n/4-1], g[0]);
        a = bb_a[n/4 < 4 ? n/4 + 1 : 4];
        b = bb_b[n/4 < 4 ? n/4 + 1 : 4];
        if (n >= 12) start = 1'b0;
      end else begin
        check($sformatf("b2b_no_done@%0d", n), {28'd0, done_v}, 32'h0);
      end
      check($sformatf("b2b_results@%0d", n), {20'd0, all_res()}, {20'd0, last_er});
    end
    @(negedge clk);
    check("b2b_idle", {24'd0, busy_v, done_v}, 32'h0);

    // Reset mid-compare: immediate clear, no done pulse, then normal operation
    @(negedge clk); a = 8'h12; b = 8'h13; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_outputs", {17'd0, busy_v, done_v, all_res()}, 32'h0);
    seen = '0;
    repeat (6) begin @(negedge clk); seen |= done_v | busy_v; end
    check("abort_no_done", {28'd0, seen}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    last_er = '0;
    run_model(8'h80, 8'h7F, 1'b0);

    // Random operands against the integer model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_model(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
